axis_packet_arbiter: RTL and testbench

Two-input AXI-Stream packet arbiter that shares a single downstream packetizing/CDC FIFO path between two packet sources. It grants the output to one source for a whole packet (grant locked until the TLAST handshake), alternates fairly between sources when both are waiting, and never interleaves beats of different packets. It sits upstream of the packetizer FIFO pair, in that FIFO pair's input clock domain.

---
 rtl/axis_packet_arbiter.sv | 111 +++++++++++
 tb/tb_axis_packet_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Two-input AXI-Stream packet arbiter: whole-packet grants, round-robin on ties, one bubble between packets.
// Optional completed-packet counters are built when ARB_PKT_COUNT_EN is defined.
module axis_packet_arbiter #(
   parameter int DW = 512
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            enable,
   output logic            idle,
   input  logic [DW-1:0]   s0_axis_tdata,
   input  logic [DW/8-1:0] s0_axis_tkeep,
   input  logic            s0_axis_tlast,
   input  logic            s0_axis_tvalid,
   output logic            s0_axis_tready,
   input  logic [DW-1:0]   s1_axis_tdata,
   input  logic [DW/8-1:0] s1_axis_tkeep,
   input  logic            s1_axis_tlast,
   input  logic            s1_axis_tvalid,
   output logic            s1_axis_tready,
   output logic [DW-1:0]   m_axis_tdata,
   output logic [DW/8-1:0] m_axis_tkeep,
   output logic            m_axis_tlast,
   output logic            m_axis_tvalid,
   input  logic            m_axis_tready,
   output logic            m_axis_tsrc
`ifdef ARB_PKT_COUNT_EN
   ,
   output logic [31:0]     pkt_count0,
   output logic [31:0]     pkt_count1
`endif
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PASS = 1'b1;

   logic [0:0] state;
   logic       sel;
   logic       last;
   logic       in_pass;
   logic       pkt_done;

   assign in_pass  = (state == ST_PASS);
   assign pkt_done = in_pass & m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // The grant is taken only from IDLE and released only by the TLAST handshake,
   // so enable never truncates a packet in flight.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
         sel   <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
                  sel   <= (s0_axis_tvalid && s1_axis_tvalid) ? ~last : s1_axis_tvalid;
                  state <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (pkt_done) begin
                  last  <= sel;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      m_axis_tdata   = '0;
      m_axis_tkeep   = '0;
      m_axis_tlast   = 1'b0;
      m_axis_tvalid  = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      if (in_pass) begin
         if (sel) begin
            m_axis_tdata   = s1_axis_tdata;
            m_axis_tkeep   = s1_axis_tkeep;
            m_axis_tlast   = s1_axis_tlast;
            m_axis_tvalid  = s1_axis_tvalid;
            s1_axis_tready = m_axis_tready;
         end else begin
            m_axis_tdata   = s0_axis_tdata;
            m_axis_tkeep   = s0_axis_tkeep;
            m_axis_tlast   = s0_axis_tlast;
            m_axis_tvalid  = s0_axis_tvalid;
            s0_axis_tready = m_axis_tready;
         end
      end
   end

   assign idle        = ~in_pass;
   assign m_axis_tsrc = sel;

`ifdef ARB_PKT_COUNT_EN
   // Counters wrap naturally at 32 bits and clear only on reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pkt_count0 <= 32'd0;
         pkt_count1 <= 32'd0;
      end else if (pkt_done) begin
         if (sel) pkt_count1 <= pkt_count1 + 32'd1;
         else     pkt_count0 <= pkt_count0 + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed vector table, directed sequences,
// and randomized traffic against a packet-level reference model.
module tb_axis_packet_arbiter;

   localparam int DW = 64;
   localparam int KW = DW / 8;
   localparam int VW = DW + KW + 6;

   localparam logic [DW-1:0] D0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [DW-1:0] D1 = 64'hFEDC_BA98_7654_3210;
   localparam logic [KW-1:0] K0 = 8'h0F;
   localparam logic [KW-1:0] K1 = 8'hF0;

   // stim = {enable, s0_valid, s0_last, s1_valid, s1_last, m_ready}
   // outv = {idle, m_valid, m_last, s0_ready, s1_ready, m_src}; dsel 0=zero, 1=s0, 2=s1
   typedef struct {
      logic [5:0] stim;
      logic [5:0] outv;
      int         dsel;
   } vec_t;

   logic          clk;
   logic          resetn;
   logic          enable;
   logic          idle;
   logic [DW-1:0] s0_axis_tdata;
   logic [KW-1:0] s0_axis_tkeep;
   logic          s0_axis_tlast;
   logic          s0_axis_tvalid;
   logic          s0_axis_tready;
   logic [DW-1:0] s1_axis_tdata;
   logic [KW-1:0] s1_axis_tkeep;
   logic          s1_axis_tlast;
   logic          s1_axis_tvalid;
   logic          s1_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tsrc;
`ifdef ARB_PKT_COUNT_EN
   logic [31:0]   pkt_count0;
   logic [31:0]   pkt_count1;
`endif

   axis_packet_arbiter #(.DW(DW)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .enable         (enable),
      .idle           (idle),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tkeep  (s0_axis_tkeep),
      .s0_axis_tlast  (s0_axis_tlast),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tready (s0_axis_tready),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tkeep  (s1_axis_tkeep),
      .s1_axis_tlast  (s1_axis_tlast),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tready (s1_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tkeep   (m_axis_tkeep),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tsrc    (m_axis_tsrc)
`ifdef ARB_PKT_COUNT_EN
      ,
      .pkt_count0     (pkt_count0),
      .pkt_count1     (pkt_count1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: which source owns the output (-1 = nobody), who won the last packet.
   int owner     = -1;
   bit pref_last = 1'b1;
   bit m_tsrc    = 1'b0;
   int m_cnt0    = 0;
   int m_cnt1    = 0;

   int beats_dut;
   int pk_dut[2];
   bit order_q[$];

   task automatic model_update();
      bit v;
      bit l;
      if (!resetn) begin
         owner     = -1;
         pref_last = 1'b1;
         m_tsrc    = 1'b0;
         m_cnt0    = 0;
         m_cnt1    = 0;
      end else if (owner < 0) begin
         if (enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
            if (s0_axis_tvalid && s1_axis_tvalid) owner = pref_last ? 0 : 1;
            else                                  owner = s1_axis_tvalid ? 1 : 0;
            m_tsrc = (owner == 1);
         end
      end else begin
         v = (owner == 0) ? s0_axis_tvalid : s1_axis_tvalid;
         l = (owner == 0) ? s0_axis_tlast  : s1_axis_tlast;
         if (v && m_axis_tready && l) begin
            pref_last = (owner == 1);
            if (owner == 0) m_cnt0++;
            else            m_cnt1++;
            owner = -1;
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic          mv, ml, r0, r1;
      logic [KW-1:0] k;
      logic [DW-1:0] d;
      mv = 1'b0; ml = 1'b0; r0 = 1'b0; r1 = 1'b0; k = '0; d = '0;
      if (owner == 0) begin
         mv = s0_axis_tvalid; ml = s0_axis_tlast; k = s0_axis_tkeep; d = s0_axis_tdata;
         r0 = m_axis_tready;
      end else if (owner == 1) begin
         mv = s1_axis_tvalid; ml = s1_axis_tlast; k = s1_axis_tkeep; d = s1_axis_tdata;
         r1 = m_axis_tready;
      end
      return {(owner < 0), mv, ml, k, d, r0, r1, m_tsrc};
   endfunction

   function automatic logic [VW-1:0] act_vec();
      return {idle, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata,
              s0_axis_tready, s1_axis_tready, m_axis_tsrc};
   endfunction

   task automatic check_vec(input string name, input logic [VW-1:0] want);
      logic [VW-1:0] got;
      got = act_vec();
      n_checks++;
      if (got !== want) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic check_int(input string name, input longint got, input longint want);
      n_checks++;
      if (got != want) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic check_output(input string name);
      #3;
      check_vec(name, exp_vec());
   endtask

   task automatic apply_stimulus(input vec_t v);
      enable         = v.stim[5];
      s0_axis_tvalid = v.stim[4];
      s0_axis_tlast  = v.stim[3];
      s1_axis_tvalid = v.stim[2];
      s1_axis_tlast  = v.stim[1];
      m_axis_tready  = v.stim[0];
      s0_axis_tdata  = D0; s0_axis_tkeep = K0;
      s1_axis_tdata  = D1; s1_axis_tkeep = K1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      s0_axis_tvalid = 1'b0;
      s1_axis_tvalid = 1'b0;
      tick();
      tick();
      check_output("reset_model");
      resetn = 1'b1;
   endtask

   function automatic int new_len(input int mode);
      if (mode == 1) return $urandom_range(1, 4);
      if (mode == 2) return 5;
      return 2;
   endfunction

   // mode 0: both always valid, 2-beat packets; 1: random traffic; 2: tready toggling
   task automatic run_sources(input int mode, input int n0, input int n1, input int limit);
      int            left[2];
      int            len[2];
      int            beat[2];
      logic [DW-1:0] base[2];
      bit            hs[2];
      bit            done;
      left[0] = n0;
      left[1] = n1;
      for (int n = 0; n < 2; n++) begin
         beat[n] = 0;
         len[n]  = new_len(mode);
         base[n] = {$urandom, $urandom};
         hs[n]   = 1'b0;
      end
      pk_dut[0] = 0;
      pk_dut[1] = 0;
      beats_dut = 0;
      order_q.delete();
      done = 1'b0;
      for (int cyc = 0; cyc < limit; cyc++) begin
         tick();
         for (int n = 0; n < 2; n++) begin
            if (hs[n]) begin
               beat[n]++;
               if (beat[n] == len[n]) begin
                  left[n]--;
                  beat[n] = 0;
                  len[n]  = new_len(mode);
                  base[n] = {$urandom, $urandom};
               end
            end
         end
         if (left[0] == 0 && left[1] == 0) begin
            done = 1'b1;
            break;
         end
         enable        = (mode == 1) ? ($urandom_range(0, 7) != 0) : 1'b1;
         m_axis_tready = (mode == 0) ? 1'b1 :
                         (mode == 1) ? ($urandom_range(0, 3) != 0) : (cyc % 2 == 1);
         s0_axis_tvalid = (left[0] > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
         s0_axis_tlast  = (beat[0] == len[0] - 1);
         s0_axis_tdata  = base[0] ^ DW'(beat[0]);
         s0_axis_tkeep  = base[0][KW-1:0] + KW'(beat[0]);
         s1_axis_tvalid = (left[1] > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
         s1_axis_tlast  = (beat[1] == len[1] - 1);
         s1_axis_tdata  = base[1] ^ DW'(beat[1]);
         s1_axis_tkeep  = base[1][KW-1:0] + KW'(beat[1]);
         check_output($sformatf("traffic_m%0d", mode));
         hs[0] = s0_axis_tvalid && (owner == 0) && m_axis_tready;
         hs[1] = s1_axis_tvalid && (owner == 1) && m_axis_tready;
         if (m_axis_tvalid && m_axis_tready) begin
            beats_dut++;
            if (m_axis_tlast) begin
               pk_dut[m_axis_tsrc]++;
               order_q.push_back(m_axis_tsrc);
            end
         end
      end
      if (!done) check_int($sformatf("drain_timeout_m%0d", mode), 0, 1);
      s0_axis_tvalid = 1'b0;
      s1_axis_tvalid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t tbl[15];
      logic [KW-1:0] k;
      logic [DW-1:0] d;

      tbl[0]  = '{6'b100001, 6'b100000, 0};
      tbl[1]  = '{6'b110101, 6'b100000, 0};
      tbl[2]  = '{6'b110101, 6'b010100, 1};
      tbl[3]  = '{6'b111101, 6'b011100, 1};
      tbl[4]  = '{6'b110101, 6'b100000, 0};
      tbl[5]  = '{6'b110100, 6'b010001, 2};
      tbl[6]  = '{6'b110111, 6'b011011, 2};
      tbl[7]  = '{6'b010101, 6'b100001, 0};
      tbl[8]  = '{6'b010101, 6'b100001, 0};
      tbl[9]  = '{6'b100111, 6'b100001, 0};
      tbl[10] = '{6'b000111, 6'b011011, 2};
      tbl[11] = '{6'b111001, 6'b100001, 0};
      tbl[12] = '{6'b101001, 6'b001100, 1};
      tbl[13] = '{6'b111101, 6'b011100, 1};
      tbl[14] = '{6'b100001, 6'b100000, 0};

      resetn = 1'b0; enable = 1'b0; m_axis_tready = 1'b0;
      s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0; s0_axis_tvalid = 1'b0;
      s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0; s1_axis_tvalid = 1'b0;

      tick();
      tick();
      check_output("reset_model");
      check_vec("reset_values", {1'b1, 1'b0, 1'b0, {KW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b0});
`ifdef ARB_PKT_COUNT_EN
      check_int("reset_count0", pkt_count0, 0);
      check_int("reset_count1", pkt_count1, 0);
`endif
      resetn = 1'b1;

      for (int i = 0; i < 15; i++) begin
         apply_stimulus(tbl[i]);
         k = (tbl[i].dsel == 1) ? K0 : (tbl[i].dsel == 2) ? K1 : '0;
         d = (tbl[i].dsel == 1) ? D0 : (tbl[i].dsel == 2) ? D1 : '0;
         #3;
         check_vec($sformatf("table_row%0d", i),
                   {tbl[i].outv[5], tbl[i].outv[4], tbl[i].outv[3], k, d,
                    tbl[i].outv[2], tbl[i].outv[1], tbl[i].outv[0]});
         tick();
      end
`ifdef ARB_PKT_COUNT_EN
      check_int("table_count0", pkt_count0, 2);
      check_int("table_count1", pkt_count1, 2);
`endif

      do_reset();
      run_sources(0, 4, 4, 200);
      check_int("fair_packets", order_q.size(), 8);
      for (int i = 0; i < order_q.size(); i++)
         check_int($sformatf("fair_order%0d", i), order_q[i], i % 2);

      run_sources(2, 0, 1, 100);
      check_int("bp_beats", beats_dut, 5);
      check_int("bp_packets_s1", pk_dut[1], 1);

      run_sources(1, 25, 25, 4000);
      check_int("rand_packets_s0", pk_dut[0], 25);
      check_int("rand_packets_s1", pk_dut[1], 25);
`ifdef ARB_PKT_COUNT_EN
      check_int("rand_count0", pkt_count0, m_cnt0);
      check_int("rand_count1", pkt_count1, m_cnt1);
`endif

      enable = 1'b1; m_axis_tready = 1'b1;
      s0_axis_tvalid = 1'b1; s0_axis_tlast = 1'b0; s0_axis_tdata = D0; s0_axis_tkeep = K0;
      s1_axis_tvalid = 1'b0;
      check_output("rm_request");
      tick();
      check_output("rm_beat1");
      tick();
      s0_axis_tdata = D0 ^ 64'd1;
      resetn = 1'b0;
      check_output("rm_beat2");
      tick();
      resetn = 1'b1;
      check_output("rm_after_reset");
      check_int("rm_idle", idle, 1);
      check_int("rm_tvalid", m_axis_tvalid, 0);
`ifdef ARB_PKT_COUNT_EN
      check_int("rm_count0_cleared", pkt_count0, 0);
      check_int("rm_count1_cleared", pkt_count1, 0);
`endif
      tick();
      s0_axis_tlast = 1'b1;
      check_output("rm_new_packet");
      tick();
      s0_axis_tvalid = 1'b0;
      check_output("rm_done");
      check_int("rm_done_idle", idle, 1);
`ifdef ARB_PKT_COUNT_EN
      check_int("rm_count0_after", pkt_count0, 1);
      check_int("rm_count1_after", pkt_count1, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
